oh_fifo_wr_arbiter: RTL
=======================

// Module: oh_fifo_wr_arbiter
// PURPOSE
//  Shares the single write port of a clock-domain-crossing FIFO among N
//  requesters in the write clock domain. Uses round-robin arbitration with
//  burst ownership: a granted requester keeps the port for up to MAXBURST
//  consecutive beats. Forwards one packet per cycle through a registered
//  output stage. wait_in connects to the FIFO pushback (prog_full).
// PARAMETERS
//  N        4    number of requesters, >=2
//  DW       104  packet width in bits
//  MAXBURST 8    max consecutive beats per grant, >=1 (1 = per-beat round robin)
// PORTS
//  clk         in   1     write-domain clock
//  nreset      in   1     async active-low reset
//  access_in   in   N     per-requester valid
//  packet_in   in   N*DW  requester i in bits [i*DW +: DW]
//  wait_out    out  N     per-requester pushback (combinational)
//  access_out  out  1     registered write strobe to FIFO
//  packet_out  out  DW    registered packet to FIFO
//  wait_in     in   1     FIFO pushback (prog_full)
//  grant       out  N     one-hot current owner, registered; 0 = none
// BEHAVIOUR
//  - Reset (async, nreset=0): access_out=0, packet_out=0, grant=0,
//    rr_ptr=0, beat count=0, state IDLE. Reset in the middle of a burst
//    drops the in-flight beat and releases ownership.
//  - Selection (combinational, each cycle):
//    * The owner continues if state=OWN, access_in[owner]=1 and count<MAXBURST.
//    * Otherwise the winner is the first i with access_in[i]=1, scanning
//      rr_ptr, rr_ptr+1, ... mod N.
//  - Accept: a beat is accepted when sel valid and wait_in=0.
//    wait_out[i] = wait_in | ~sel[i].
//  - Latency 1: on an accepted beat, at the next clk edge access_out<=1 and
//    packet_out<=packet_in[sel].
//  - No accept: access_out<=0; packet_out holds its value.
//  - New grant (winner != current owner, or state was IDLE):
//    * grant<=onehot(winner), count<=1, rr_ptr<=(winner+1) mod N, state OWN.
//    * Re-arbitration costs no bubble: the new winner is accepted in the same
//      cycle the previous owner releases.
//  - Continuing owner: count<=count+1 on each accepted beat.
//  - Release to IDLE (grant<=0) when no sel is valid and wait_in=0.
//  - Burst cap: count==MAXBURST forces re-arbitration. rr_ptr already points
//    past the owner, so the owner gets lowest priority; it regains the grant
//    only if no other requester is active.
//  - wait_in=1 freezes state, grant, count and rr_ptr; no beat is accepted.
//  - Width rules: count is clog2(MAXBURST+1) bits and never exceeds MAXBURST.
//    rr_ptr is clog2(N) bits and wraps N-1 -> 0.
//  - Requesters follow the codebase rule: hold access_in and packet_in stable
//    while wait_out[i]=1. The arbiter never drops or duplicates a beat.
//  - Packet order within one requester is preserved. No ordering is
//    guaranteed across requesters.
// TESTING
//  1 Reset: nreset=0 with all access_in=1 -> access_out=0, packet_out=0,
//    grant=0, wait_out=4'b1111 (sel invalid); release -> req0 is granted first.
//  2 Single requester: access_in=4'b0100 for 20 cycles, MAXBURST=8 ->
//    20 contiguous beats from req2, 1-cycle latency, no bubbles, in order.
//  3 All active, MAXBURST=8 -> bursts of 8 from req0,1,2,3,0..., owner
//    changes with zero idle cycles, wait_out low only for the owner.
//  4 Backpressure: wait_in=1 for 5 cycles mid-burst (count=3) ->
//    access_out=0 for those cycles, count stays 3, burst resumes at beat 4
//    with no loss or duplication.
//  5 Owner drops access after 2 beats while req3 waits; rr_ptr=1 ->
//    req3 wins in the same cycle, rr_ptr becomes 0.
//  6 Async reset during a burst -> outputs clear immediately; after release,
//    arbitration restarts from req0; random scoreboard shows no duplicates.

Source files
------------

// File: rtl/oh_fifo_wr_arbiter.sv
// Round-robin write-port arbiter with burst ownership for a CDC FIFO.
// Selection is combinational; the FIFO-facing write strobe, packet and grant are registered.
module oh_fifo_wr_arbiter #(
   parameter int N        = 4,
   parameter int DW       = 104,
   parameter int MAXBURST = 8
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic [N-1:0]    access_in,
   input  logic [N*DW-1:0] packet_in,
   output logic [N-1:0]    wait_out,
   output logic            access_out,
   output logic [DW-1:0]   packet_out,
   input  logic            wait_in,
   output logic [N-1:0]    grant
);

   localparam int IW = $clog2(N);
   localparam int CW = $clog2(MAXBURST + 1);
   localparam logic [CW-1:0] MAXB = CW'(MAXBURST);

   typedef enum logic {ST_IDLE, ST_OWN} state_t;

   state_t          r_state, w_state_next;
   logic [IW-1:0]   r_owner, w_owner_next;
   logic [IW-1:0]   r_rr_ptr, w_rr_next;
   logic [CW-1:0]   r_count, w_count_next;
   logic [N-1:0]    r_grant, w_grant_next;
   logic            r_access;
   logic [DW-1:0]   r_packet;

   logic [IW:0]     w_scan;
   logic [IW-1:0]   w_sel_idx;
   logic [N-1:0]    w_sel_onehot;
   logic [N-1:0]    w_req;
   logic            w_sel_valid;
   logic            w_continue;
   logic            w_accept;
   logic [DW-1:0]   w_sel_pkt;

   // First active requester at or after ptr (mod N); MSB flags a hit.
   function automatic logic [IW:0] rr_scan(input logic [IW-1:0] ptr, input logic [N-1:0] req);
      int j;
      rr_scan = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N;
         if (req[j]) rr_scan = {1'b1, IW'(j)};
      end
   endfunction

   // Nothing is selectable while reset is held, so every requester sees pushback.
   assign w_req      = access_in & {N{nreset}};
   assign w_continue = (r_state == ST_OWN) && w_req[r_owner] && (r_count < MAXB);
   assign w_scan     = rr_scan(r_rr_ptr, w_req);
   assign w_sel_valid = w_continue | w_scan[IW];
   assign w_sel_idx   = w_continue ? r_owner : w_scan[IW-1:0];
   assign w_accept    = w_sel_valid & ~wait_in;
   assign w_sel_pkt   = packet_in[w_sel_idx*DW +: DW];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_sel
         assign w_sel_onehot[gi] = w_sel_valid && (w_sel_idx == IW'(gi));
         assign wait_out[gi]     = wait_in | ~w_sel_onehot[gi];
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      w_owner_next = r_owner;
      w_count_next = r_count;
      w_rr_next    = r_rr_ptr;
      w_grant_next = r_grant;
      if (!wait_in) begin
         if (!w_sel_valid) begin
            w_state_next = ST_IDLE;
            w_grant_next = '0;
            w_count_next = '0;
         end else if (w_continue) begin
            w_count_next = r_count + 1'b1;
         end else begin
            // Any non-continuing selection (including a capped owner winning again) restarts the burst.
            w_state_next = ST_OWN;
            w_owner_next = w_sel_idx;
            w_count_next = CW'(1);
            w_rr_next    = (w_sel_idx == IW'(N - 1)) ? '0 : w_sel_idx + 1'b1;
            w_grant_next = w_sel_onehot;
         end
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state  <= ST_IDLE;
         r_owner  <= '0;
         r_rr_ptr <= '0;
         r_count  <= '0;
         r_grant  <= '0;
         r_access <= 1'b0;
         r_packet <= '0;
      end else begin
         r_state  <= w_state_next;
         r_owner  <= w_owner_next;
         r_rr_ptr <= w_rr_next;
         r_count  <= w_count_next;
         r_grant  <= w_grant_next;
         r_access <= w_accept;
         if (w_accept) r_packet <= w_sel_pkt;
      end
   end

   assign access_out = r_access;
   assign packet_out = r_packet;
   assign grant      = r_grant;

endmodule
